// File: rtl/weight_stream_sched.sv
// weight_stream_sched
//   Streams per-layer weights out of one shared weight memory. On start it
//   walks the length table from layer 0 upward, skipping empty layers, and
//   issues one memory read per cycle for each word. Returned words go through
//   a 2-entry ordered FIFO tagged with their layer. The FIFO head drives a
//   shared data bus and a one-hot per-layer valid.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   cfg_wr/cfg_layer/   length-table write port (accepted only while idle)
//   cfg_len
//   base_addr, start    memory address of layer 0 word 0, pass start pulse
//   mem_rd_en/mem_addr  read request to the weight memory
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   weight_out          weight word on the shared bus
//   weight_valid        one-hot owner layer of weight_out (0 = no word)
//   weight_ready        per-layer accept
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   cur_layer           layer currently being issued
module weight_stream_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LAYERS = 14,
  parameter int ADDR_WIDTH = 24,
  parameter int LAYER_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_wr,
  input  logic [LAYER_BITS-1:0] cfg_layer,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic [NUM_LAYERS-1:0] weight_valid,
  input  logic [NUM_LAYERS-1:0] weight_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LAYER_BITS-1:0] cur_layer
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEEK       = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_DRAIN = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q [NUM_LAYERS];
  logic [LAYER_BITS-1:0] cur_layer_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  infl_q;
  logic [LAYER_BITS-1:0] infl_layer_q;
  logic [DATA_WIDTH-1:0] fifo_data_q  [2];
  logic [LAYER_BITS-1:0] fifo_layer_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;
  logic                  busy_q, done_q;

  logic                  seek_found_s;
  logic [LAYER_BITS-1:0] seek_idx_s;
  int                    seek_from_s;
  logic [LAYER_BITS-1:0] head_layer_s;
  logic                  pop_s;
  logic                  credit_ok_s;
  logic                  drained_s;
  logic                  rd_en_s;
  logic                  load_s;
  logic [NUM_LAYERS-1:0] valid_s;

  // FIFO head decode, transfer detection and read credit.
  // Credit counts the entry being popped this cycle as free, which is what
  // lets a 2-entry FIFO sustain one word per cycle.
  always_comb begin
    head_layer_s = fifo_layer_q[rd_ptr_q];
    pop_s        = (fifo_cnt_q != 2'd0) && weight_ready[head_layer_s];
    credit_ok_s  = (({1'b0, fifo_cnt_q} + {2'b00, infl_q}) - {2'b00, pop_s}) < 3'd2;
    drained_s    = !infl_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop_s));
    valid_s      = '0;
    if (fifo_cnt_q != 2'd0) begin
      valid_s[head_layer_s] = 1'b1;
    end else begin
      valid_s = '0;
    end
  end

  // Lowest non-empty layer at or above the search origin. The origin is 0
  // at the start of a pass and cur_layer+1 when a layer finishes issuing, so
  // back-to-back layers follow each other without an idle cycle.
  always_comb begin
    seek_found_s = 1'b0;
    seek_idx_s   = '0;
    seek_from_s  = (state_q == S_SEEK) ? 0 : (int'(cur_layer_q) + 1);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      seek_found_s = seek_found_s | ((i >= seek_from_s) && (len_q[i] != '0));
      seek_idx_s   = ((i >= seek_from_s) && (len_q[i] != '0)) ? LAYER_BITS'(i) : seek_idx_s;
    end
  end

  // Pass sequencer: next state, read strobe and layer-load decision.
  always_comb begin
    state_d = state_q;
    rd_en_s = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SEEK;
        else       state_d = S_IDLE;
      end
      S_SEEK: begin
        if (seek_found_s) begin
          load_s  = 1'b1;
          state_d = S_ISSUE;
        end else if (drained_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_DRAIN;
        end
      end
      S_ISSUE: begin
        if (credit_ok_s) begin
          rd_en_s = 1'b1;
          if (rem_q == ADDR_WIDTH'(1)) begin
            if (seek_found_s) load_s = 1'b1;
            else              state_d = S_WAIT_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_DRAIN: begin
        if (drained_s) state_d = S_DONE;
        else           state_d = S_WAIT_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Length table; writes accepted only while idle and for valid indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) len_q[i] <= '0;
    end else if (cfg_wr && (state_q == S_IDLE) && (int'(cfg_layer) < NUM_LAYERS)) begin
      len_q[cfg_layer] <= cfg_len;
    end
  end

  // Sequencer state, address/word counters and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_layer_q  <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      infl_q       <= 1'b0;
      infl_layer_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      infl_q       <= rd_en_s;
      infl_layer_q <= cur_layer_q;
      if (load_s) begin
        cur_layer_q <= seek_idx_s;
        rem_q       <= len_q[seek_idx_s];
      end else if (rd_en_s) begin
        rem_q <= rem_q - ADDR_WIDTH'(1);
      end
      if ((state_q == S_IDLE) && start) addr_q <= base_addr;
      else if (rd_en_s)                 addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  // Ordered 2-entry FIFO of {layer, data}; captures the word returned for
  // the read issued last cycle. Reset drops any word still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_layer_q[0] <= '0;
      fifo_layer_q[1] <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      if (infl_q) begin
        fifo_data_q[wr_ptr_q]  <= mem_rd_data;
        fifo_layer_q[wr_ptr_q] <= infl_layer_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop_s) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= (fifo_cnt_q + {1'b0, infl_q}) - {1'b0, pop_s};
    end
  end

  assign mem_rd_en    = rd_en_s;
  assign mem_addr     = addr_q;
  assign weight_out   = fifo_data_q[rd_ptr_q];
  assign weight_valid = valid_s;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_layer    = cur_layer_q;

endmodule

// File: tb/tb_weight_stream_sched.sv
// Self-checking bench for weight_stream_sched: table of full load passes with
// a small memory model and a scoreboard of expected addresses, words and
// owning layers, plus a hand-written mid-pass reset sequence.
module tb_weight_stream_sched;
  localparam int DW = 32;
  localparam int NL = 14;
  localparam int AW = 24;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_wr;
  logic [LB-1:0] cfg_layer;
  logic [AW-1:0] cfg_len;
  logic [AW-1:0] base_addr;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] weight_out;
  logic [NL-1:0] weight_valid;
  logic [NL-1:0] weight_ready;
  logic          busy;
  logic          done;
  logic [LB-1:0] cur_layer;

  weight_stream_sched #(.DATA_WIDTH(DW), .NUM_LAYERS(NL), .ADDR_WIDTH(AW), .LAYER_BITS(LB)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer), .cfg_len(cfg_len),
    .base_addr(base_addr), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .weight_out(weight_out), .weight_valid(weight_valid),
    .weight_ready(weight_ready), .busy(busy), .done(done), .cur_layer(cur_layer)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8'hC3, a} ^ 32'h0055AA00;
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? word_of(mem_addr) : 32'hBAD0BAD0;

  typedef struct {
    logic          prog;
    logic          poke;
    logic          stall;
    logic [AW-1:0] base;
    logic [AW-1:0] l0, l1, l2, l13;
    int            exp_words;
    int            exp_done;
    int            exp_addr2;
  } vec_t;

  vec_t          vecs [7];
  logic [AW-1:0] m_len [NL];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int layer_of(input int k);
    int acc = 0;
    for (int i = 0; i < NL; i++) begin
      if (k < acc + int'(m_len[i])) return i;
      acc += int'(m_len[i]);
    end
    return -1;
  endfunction

  // Programs (optionally), starts a pass and scoreboards it. Called with the
  // bench sitting 1 time unit after a rising edge. abort_at > 0 leaves the
  // pass running at that cycle without end-of-pass checks.
  task automatic run_vec(input vec_t v, input string tag, input int abort_at);
    int nreads = 0, xfers = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1;
    int addr_err = 0, data_err = 0, onehot_err = 0, hold_err = 0, max_out = 0;
    int first_v = -1, last_v = -1, stall_left = 5, lay;
    logic [AW-1:0] addr2 = '0;
    logic hold_pend = 1'b0;
    logic [DW-1:0] prev_out = '0;
    logic [NL-1:0] prev_valid = '0;
    if (v.prog) begin
      for (int i = 0; i < NL; i++) m_len[i] = '0;
      m_len[0] = v.l0; m_len[1] = v.l1; m_len[2] = v.l2; m_len[13] = v.l13;
      for (int i = 1; i < NL; i++) begin
        cfg_wr = 1'b1; cfg_layer = LB'(i); cfg_len = m_len[i];
        @(posedge clk); #1;
      end
      cfg_layer = 4'd15; cfg_len = 24'd5;
      @(posedge clk); #1;
      cfg_wr = 1'b1; cfg_layer = 4'd0; cfg_len = v.l0;   // same cycle as start
    end else begin
      cfg_wr = 1'b0;
    end
    start = 1'b1; base_addr = v.base;
    @(posedge clk); #1;
    start = 1'b0; cfg_wr = 1'b0; base_addr = 24'h5A5A5A;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (cyc == abort_at) break;
      if (v.stall && xfers == 2 && stall_left > 0) begin
        weight_ready = {{(NL-1){1'b1}}, 1'b0};
        stall_left--;
      end else begin
        weight_ready = '1;
      end
      if (v.poke && cyc == 3) begin
        start = 1'b1; cfg_wr = 1'b1; cfg_layer = 4'd0; cfg_len = 24'd9;
      end else begin
        start = 1'b0; cfg_wr = 1'b0;
      end
      @(negedge clk);
      if (nreads - xfers > max_out) max_out = nreads - xfers;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mem_rd_en) begin
        if (mem_addr != v.base + AW'(nreads)) addr_err++;
        if (nreads == 2) addr2 = mem_addr;
        nreads++;
      end
      if ($countones(weight_valid) > 1) onehot_err++;
      if (hold_pend && (weight_valid != prev_valid || weight_out != prev_out)) hold_err++;
      hold_pend = 1'b0;
      if (weight_valid != '0) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if ((weight_valid & weight_ready) != '0) begin
          lay = layer_of(xfers);
          if (lay < 0) data_err++;
          else if (weight_valid != (NL'(1) << lay) || weight_out != word_of(v.base + AW'(xfers))) data_err++;
          xfers++;
        end else begin
          hold_pend = 1'b1; prev_valid = weight_valid; prev_out = weight_out;
        end
      end
      @(posedge clk); #1;
      if (done_cyc > 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0; cfg_wr = 1'b0;
    if (abort_at > 0) return;
    check({tag, "_reads"}, nreads, v.exp_words);
    check({tag, "_xfers"}, xfers, v.exp_words);
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_done);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    check({tag, "_addr_seq_errs"}, addr_err, 0);
    check({tag, "_data_layer_errs"}, data_err, 0);
    check({tag, "_onehot_errs"}, onehot_err, 0);
    check({tag, "_hold_errs"}, hold_err, 0);
    check({tag, "_outstanding_le2"}, (max_out <= 2), 1);
    if (v.exp_addr2 >= 0) check({tag, "_addr2"}, addr2, v.exp_addr2);
    if (!v.stall && v.exp_words > 0) check({tag, "_no_gap"}, last_v - first_v + 1, v.exp_words);
    if (v.exp_words == 0) check({tag, "_no_valid"}, first_v, -1);
  endtask

  initial begin
    vecs[0] = '{prog:1'b1, poke:1'b0, stall:1'b0, base:24'h000100, l0:24'd4, l1:24'd0, l2:24'd3, l13:24'd0,
                exp_words:7, exp_done:11, exp_addr2:32'h102};
    vecs[1] = '{prog:1'b1, poke:1'b0, stall:1'b1, base:24'h000100, l0:24'd4, l1:24'd0, l2:24'd3, l13:24'd0,
                exp_words:7, exp_done:16, exp_addr2:32'h102};
    vecs[2] = '{prog:1'b1, poke:1'b1, stall:1'b0, base:24'h000100, l0:24'd4, l1:24'd0, l2:24'd3, l13:24'd0,
                exp_words:7, exp_done:11, exp_addr2:32'h102};
    vecs[3] = '{prog:1'b0, poke:1'b0, stall:1'b0, base:24'h000100, l0:24'd4, l1:24'd0, l2:24'd3, l13:24'd0,
                exp_words:7, exp_done:11, exp_addr2:32'h102};
    vecs[4] = '{prog:1'b1, poke:1'b0, stall:1'b0, base:24'h000200, l0:24'd0, l1:24'd0, l2:24'd0, l13:24'd0,
                exp_words:0, exp_done:2, exp_addr2:-1};
    vecs[5] = '{prog:1'b1, poke:1'b0, stall:1'b0, base:24'hFFFFFE, l0:24'd4, l1:24'd0, l2:24'd0, l13:24'd0,
                exp_words:4, exp_done:8, exp_addr2:32'h000000};
    vecs[6] = '{prog:1'b1, poke:1'b0, stall:1'b0, base:24'h000010, l0:24'd0, l1:24'd2, l2:24'd0, l13:24'd1,
                exp_words:3, exp_done:7, exp_addr2:32'h000012};

    reset = 1'b0; cfg_wr = 1'b0; cfg_layer = '0; cfg_len = '0; base_addr = '0; start = 1'b0;
    weight_ready = '1;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", weight_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("v%0d", k), 0);

    // Reset in the middle of layer 0 with a read in flight.
    run_vec(vecs[0], "abort", 6);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", weight_valid, 0);
    check("midrst_data", weight_out, 0);
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_layer", cur_layer, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_valid", weight_valid, 0);
    check("postrst_busy", busy, 0);
    @(posedge clk); #1;
    run_vec(vecs[0], "after_rst", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
